id_ex_pipe_stage: RTL
=====================

// Module: id_ex_pipe_stage
// PURPOSE
//  Parametrised ID/EX pipeline register for the MIPS core.
//  - Carries PC, operands, immediate, register addresses and the decoded control bundle from decode to execute.
//  - Adds a valid bit, stall, flush (bubble insertion), run/step debug advance and an advance counter.
//  - With ID_EX_DEBUG_EN, adds a registered debug readback mux for the debug unit.
// PARAMETERS
//  NB_DATA  32  width of PC, operand and immediate fields
//  NB_REG   5   register-address width (rs, rt, rd)
//  NB_CTRL  16  width of the decoded control bundle
//  NB_CNT   32  width of the advance counter
// PORTS
//  i_clk        in   1        clock, all state on rising edge
//  i_reset      in   1        asynchronous active-low reset
//  i_mode_step  in   1        0 = run (advance every cycle), 1 = step mode
//  i_step       in   1        step request level; rising edge advances once in step mode
//  i_stall      in   1        hold stage contents (hazard unit)
//  i_flush      in   1        load a bubble (branch/jump squash)
//  i_valid      in   1        decode-stage instruction valid
//  i_pc         in   NB_DATA  PC+4 of the decoded instruction
//  i_rs_data    in   NB_DATA  rs operand
//  i_rt_data    in   NB_DATA  rt operand
//  i_imm        in   NB_DATA  sign/zero-extended immediate
//  i_rs, i_rt, i_rd  in  NB_REG  register addresses
//  i_ctrl       in   NB_CTRL  control bundle
//  o_valid, o_pc, o_rs_data, o_rt_data, o_imm, o_rs, o_rt, o_rd, o_ctrl  out  (widths as inputs)  registered stage contents
//  o_advance    out  1        combinational: the stage updates on this edge
//  o_adv_count  out  NB_CNT   number of advances since reset
//  i_dbg_sel    in   3        debug field select
//  o_dbg_data   out  NB_DATA  registered debug readback
// BEHAVIOUR
//  - Reset (i_reset = 0, async): all stage registers, the step edge register, o_adv_count and o_dbg_data clear to 0.
//    o_valid = 0; the stage presents a bubble.
//  - Edge detect: step_q <= i_step every cycle regardless of mode. step_rise = i_step & ~step_q.
//    Entering step mode with i_step already high produces no spurious advance.
//  - Advance enable: en = i_mode_step ? step_rise : 1'b1.
//  - Priority per edge: reset > (en & i_flush) > (en & i_stall) > en > idle.
//    - Flush: all stage fields <= 0, o_valid <= 0. Flush wins over a simultaneous stall.
//    - Stall: all fields hold.
//    - Load: all fields <= inputs, o_valid <= i_valid.
//    - ~en: all fields hold; flush and stall are ignored. The hazard unit holds them until the step.
//  - o_advance = en & ~i_stall | en & i_flush.
//  - o_adv_count: increments by 1 on every cycle with o_advance = 1 (flush included, stall excluded).
//    Wraps modulo 2^NB_CNT.
//  - Latency: 1 cycle input-to-output on a load edge.
//  - Mode switch mid-stream: contents are never lost; the next advance follows the new mode.
//  - Async reset mid-stall or mid-step clears immediately. The first post-reset edge may load in run mode.
// CONFIGURATION
//  ID_EX_DEBUG_EN defined: o_dbg_data is registered every cycle (1-cycle latency) from i_dbg_sel:
//    0 o_pc | 1 o_rs_data | 2 o_rt_data | 3 o_imm
//    4 {o_rs,o_rt,o_rd} zero-extended | 5 o_ctrl zero-extended
//    6 o_adv_count (truncated or zero-extended to NB_DATA) | 7 {o_valid} zero-extended
//  ID_EX_DEBUG_EN undefined: o_dbg_data tied to 0; ports remain so the interface is unchanged.
// TESTING
//  1. Run mode: pc=0x4, rd=3, valid=1 applied -> next edge o_pc=0x4, o_rd=3, o_valid=1, o_adv_count=1.
//  2. Stall + flush same cycle in run mode -> o_valid=0, o_ctrl=0, all fields 0, count increments.
//     Stall alone for 3 cycles -> outputs hold, count unchanged.
//  3. Step mode: i_step held high 5 cycles with inputs changing -> exactly one load, count +1.
//     i_step low then high again -> second load.
//  4. Switch to step mode while i_step=1 -> no advance until i_step falls and rises.
//  5. Assert i_reset=0 between edges mid-stall -> outputs clear 0 asynchronously, before the next clock edge.
//  6. ID_EX_DEBUG_EN: after load of rs=1, rt=2, rd=3, sel=4 -> next cycle o_dbg_data=0x443.
//     Without the macro -> o_dbg_data=0.
//     NB_CNT=4, 17 advances -> o_adv_count=1 (wrap).

Source files
------------

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register: decoded fields, valid bit, stall/flush, run/step advance, advance counter; ID_EX_DEBUG_EN adds a debug readback mux.
// Latency: 1 cycle input-to-output on a load edge; debug readback is registered (1 more cycle).
// Backpressure: i_stall holds contents; i_flush wins over stall and loads a bubble; nothing moves without an advance.
module id_ex_pipe_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CTRL = 16,
    parameter int NB_CNT  = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_mode_step,
    input  logic               i_step,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_pc,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic [NB_DATA-1:0] i_imm,
    input  logic [NB_REG-1:0]  i_rs,
    input  logic [NB_REG-1:0]  i_rt,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic [NB_CTRL-1:0] i_ctrl,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_pc,
    output logic [NB_DATA-1:0] o_rs_data,
    output logic [NB_DATA-1:0] o_rt_data,
    output logic [NB_DATA-1:0] o_imm,
    output logic [NB_REG-1:0]  o_rs,
    output logic [NB_REG-1:0]  o_rt,
    output logic [NB_REG-1:0]  o_rd,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic               o_advance,
    output logic [NB_CNT-1:0]  o_adv_count,
    input  logic [2:0]         i_dbg_sel,
    output logic [NB_DATA-1:0] o_dbg_data
);

    logic step_q;
    logic step_rise;
    logic en;

    // step_q tracks i_step in every mode, so entering step mode with i_step high cannot fire
    assign step_rise = i_step & ~step_q;
    assign en        = i_mode_step ? step_rise : 1'b1;
    assign o_advance = (en & ~i_stall) | (en & i_flush);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= i_step;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_valid   <= 1'b0;
            o_pc      <= '0;
            o_rs_data <= '0;
            o_rt_data <= '0;
            o_imm     <= '0;
            o_rs      <= '0;
            o_rt      <= '0;
            o_rd      <= '0;
            o_ctrl    <= '0;
        end else if (en & i_flush) begin
            o_valid   <= 1'b0;
            o_pc      <= '0;
            o_rs_data <= '0;
            o_rt_data <= '0;
            o_imm     <= '0;
            o_rs      <= '0;
            o_rt      <= '0;
            o_rd      <= '0;
            o_ctrl    <= '0;
        end else if (en & ~i_stall) begin
            o_valid   <= i_valid;
            o_pc      <= i_pc;
            o_rs_data <= i_rs_data;
            o_rt_data <= i_rt_data;
            o_imm     <= i_imm;
            o_rs      <= i_rs;
            o_rt      <= i_rt;
            o_rd      <= i_rd;
            o_ctrl    <= i_ctrl;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_adv_count <= '0;
        end else if (o_advance) begin
            o_adv_count <= o_adv_count + NB_CNT'(1);
        end
    end

`ifdef ID_EX_DEBUG_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_dbg_data <= '0;
        end else begin
            case (i_dbg_sel)
                3'd0:    o_dbg_data <= o_pc;
                3'd1:    o_dbg_data <= o_rs_data;
                3'd2:    o_dbg_data <= o_rt_data;
                3'd3:    o_dbg_data <= o_imm;
                3'd4:    o_dbg_data <= NB_DATA'({o_rs, o_rt, o_rd});
                3'd5:    o_dbg_data <= NB_DATA'(o_ctrl);
                3'd6:    o_dbg_data <= NB_DATA'(o_adv_count);
                default: o_dbg_data <= NB_DATA'(o_valid);
            endcase
        end
    end
`else
    logic unused_dbg_sel;
    assign unused_dbg_sel = ^i_dbg_sel;
    assign o_dbg_data     = '0;
`endif

endmodule
